// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter that loads one of R requester words into a shared
// holding register with a valid/ready handshake toward the consumer.
module rr_reg_arbiter #(
  parameter int unsigned N = 8,
  parameter int unsigned R = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [R-1:0]   req,
  input  logic [R*N-1:0] req_data,
  output logic [R-1:0]   gnt,
  output logic [N-1:0]   q,
  output logic           q_valid,
  input  logic           q_ready,
  output logic [1:0]     q_owner
);

  localparam int unsigned OW = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e        state_q;
  logic [OW-1:0] ptr_q;
  logic [OW-1:0] owner_q;
  logic [N-1:0]  data_q;

  logic [OW-1:0] idx;
  logic [OW-1:0] win_c;
  logic          found_c;
  logic          capture_c;

  // Round-robin search starting at ptr_q, wrapping naturally through the 2-bit index.
  always_comb begin
    idx     = '0;
    win_c   = '0;
    found_c = 1'b0;
    for (int unsigned k = 0; k < R; k++) begin
      idx = ptr_q + OW'(k);
      if (!found_c && req[idx]) begin
        found_c = 1'b1;
        win_c   = idx;
      end
    end
  end

  // A capture happens when someone requests and the register is empty or being consumed.
  always_comb begin
    capture_c = found_c && ((state_q == IDLE) || q_ready) && !reset;
    gnt       = capture_c ? (R'(1) << win_c) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (capture_c) begin
            data_q  <= req_data[32'(win_c) * N +: N];
            owner_q <= win_c;
            ptr_q   <= win_c + OW'(1);
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (capture_c) begin
            data_q  <= req_data[32'(win_c) * N +: N];
            owner_q <= win_c;
            ptr_q   <= win_c + OW'(1);
          end else if (q_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign q       = data_q;
  assign q_owner = owner_q;
  assign q_valid = (state_q == HOLD);

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Self-checking bench for rr_reg_arbiter: directed scenarios plus random traffic
// compared against a transaction-level round-robin model.
module tb_rr_reg_arbiter;

  localparam int N = 8;
  localparam int R = 4;

  logic           clk;
  logic           reset;
  logic [R-1:0]   req;
  logic [R*N-1:0] req_data;
  logic [R-1:0]   gnt;
  logic [N-1:0]   q;
  logic           q_valid;
  logic           q_ready;
  logic [1:0]     q_owner;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int       m_ptr;
  bit       m_valid;
  bit [7:0] m_q;
  int       m_owner;

  rr_reg_arbiter #(.N(N), .R(R)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .gnt(gnt),
    .q(q), .q_valid(q_valid), .q_ready(q_ready), .q_owner(q_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pick_winner(input int ptr, input bit [3:0] r);
    for (int off = 0; off < 4; off++) begin
      if (r[(ptr + off) % 4]) return (ptr + off) % 4;
    end
    return -1;
  endfunction

  function automatic bit [14:0] exp_vec(input bit [3:0] g);
    return {g, m_valid, 2'(m_owner), m_q};
  endfunction

  function automatic bit [14:0] obs_vec(input bit [3:0] g);
    return {g, q_valid, q_owner, q};
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_q = 8'h00; m_owner = 0;
  endtask

  // Apply one cycle of inputs (from posedge+1), sample gnt at the negedge,
  // advance the model at the posedge and return at posedge+1.
  task automatic do_cycle(input bit [3:0] r, input bit [31:0] d, input bit rdy,
                          output bit [3:0] g_obs, output bit [3:0] g_exp);
    int w;
    bit cap;
    req = r; req_data = d; q_ready = rdy;
    w   = pick_winner(m_ptr, r);
    cap = (w >= 0) && (!m_valid || rdy);
    g_exp = cap ? 4'(1 << w) : 4'b0000;
    @(negedge clk);
    g_obs = gnt;
    @(posedge clk);
    if (cap) begin
      m_q = d[w*8 +: 8]; m_owner = w; m_valid = 1; m_ptr = (w + 1) % 4;
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    req = '0; q_ready = 1'b0; req_data = '0;
    reset = 1'b1;
    #12;
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bit [3:0] go, ge;
    req = 4'b1111; req_data = 32'h44332211; q_ready = 1'b1;
    reset = 1'b1;
    #7;
    n_checks++;
    if ({gnt, q, q_valid, q_owner} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_state: gnt=%b q=%h q_valid=%b q_owner=%0d, required all zero",
               gnt, q, q_valid, q_owner);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    do_cycle(4'b1111, 32'h44332211, 1'b1, go, ge);
    n_checks++;
    if (obs_vec(go) !== exp_vec(ge) || go !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_first_grant: got %h required %h (gnt %b)", obs_vec(go), exp_vec(ge), go);
    end
  endtask

  task automatic test_round_robin();
    bit [3:0] go, ge;
    bit [7:0] want_q [5] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      do_cycle(4'b1111, 32'h43322110, 1'b1, go, ge);
      n_checks++;
      if (obs_vec(go) !== exp_vec(ge) || go !== 4'(1 << (i % 4)) || q !== want_q[i]) begin
        n_fail++;
        $display("FAIL round_robin[%0d]: got %h required %h", i, obs_vec(go), exp_vec(ge));
      end
    end
  endtask

  task automatic test_backpressure();
    bit [3:0] go, ge;
    do_reset();
    do_cycle(4'b0100, 32'h00A50000, 1'b0, go, ge);
    for (int i = 0; i < 5; i++) begin
      do_cycle(4'b0010, 32'h0000BE00, 1'b0, go, ge);
      n_checks++;
      if (obs_vec(go) !== exp_vec(ge) || q !== 8'hA5 || q_owner !== 2'd2 || go !== 4'b0000) begin
        n_fail++;
        $display("FAIL backpressure_hold[%0d]: got %h required %h", i, obs_vec(go), exp_vec(ge));
      end
    end
    do_cycle(4'b0010, 32'h0000BE00, 1'b1, go, ge);
    n_checks++;
    if (obs_vec(go) !== exp_vec(ge) || go !== 4'b0010 || q !== 8'hBE) begin
      n_fail++;
      $display("FAIL backpressure_release: got %h required %h", obs_vec(go), exp_vec(ge));
    end
  endtask

  task automatic test_drain();
    bit [3:0] go, ge;
    do_reset();
    do_cycle(4'b0001, 32'h0000005A, 1'b0, go, ge);
    do_cycle(4'b0000, 32'hFFFFFFFF, 1'b1, go, ge);
    n_checks++;
    if (obs_vec(go) !== exp_vec(ge) || q_valid !== 1'b0 || q !== 8'h5A) begin
      n_fail++;
      $display("FAIL drain: got %h required %h", obs_vec(go), exp_vec(ge));
    end
    do_cycle(4'b0000, 32'h0, 1'b1, go, ge);
    n_checks++;
    if (obs_vec(go) !== exp_vec(ge)) begin
      n_fail++;
      $display("FAIL drain_idle: got %h required %h", obs_vec(go), exp_vec(ge));
    end
  endtask

  task automatic test_pointer_wrap();
    bit [3:0] go, ge;
    do_reset();
    do_cycle(4'b1000, 32'h77000000, 1'b1, go, ge);
    do_cycle(4'b1001, 32'h88000099, 1'b1, go, ge);
    n_checks++;
    if (obs_vec(go) !== exp_vec(ge) || go !== 4'b0001 || q_owner !== 2'd0) begin
      n_fail++;
      $display("FAIL pointer_wrap: got %h required %h", obs_vec(go), exp_vec(ge));
    end
  endtask

  task automatic test_mid_reset();
    bit [3:0] go, ge;
    do_reset();
    do_cycle(4'b0010, 32'h00003300, 1'b0, go, ge);
    req = 4'b1111; q_ready = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({gnt, q, q_valid, q_owner} !== 15'd0) begin
      n_fail++;
      $display("FAIL mid_reset_async: gnt=%b q=%h q_valid=%b q_owner=%0d, required all zero",
               gnt, q, q_valid, q_owner);
    end
    #1;
    reset = 1'b0;
    req = 4'b0000;
    model_reset();
    @(posedge clk); #1;
    do_cycle(4'b0100, 32'h00C10000, 1'b0, go, ge);
    n_checks++;
    if (obs_vec(go) !== exp_vec(ge) || q_owner !== 2'd2 || q !== 8'hC1 || q_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_recapture: got %h required %h", obs_vec(go), exp_vec(ge));
    end
  endtask

  task automatic test_random(input int cycles);
    bit [3:0]  go, ge, r;
    bit [31:0] d;
    bit        rdy;
    do_reset();
    for (int i = 0; i < cycles; i++) begin
      r   = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      d   = $urandom;
      rdy = ($urandom_range(0, 2) != 0);
      do_cycle(r, d, rdy, go, ge);
      n_checks++;
      if (obs_vec(go) !== exp_vec(ge)) begin
        n_fail++;
        $display("FAIL random[%0d]: req=%b rdy=%b got %h required %h", i, r, rdy, obs_vec(go), exp_vec(ge));
      end
    end
  endtask

  // Every requester held continuously must win within four captures.
  task automatic test_fairness();
    bit [3:0] go, ge;
    int       wait_cnt [4];
    do_reset();
    for (int k = 0; k < 4; k++) wait_cnt[k] = 0;
    for (int i = 0; i < 40; i++) begin
      do_cycle(4'b1111, $urandom, 1'b1, go, ge);
      for (int k = 0; k < 4; k++) wait_cnt[k] = go[k] ? 0 : wait_cnt[k] + 1;
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (wait_cnt[k] >= 4) begin
        n_fail++;
        $display("FAIL fairness[%0d]: waited %0d captures, required < 4", k, wait_cnt[k]);
      end
    end
  endtask

  initial begin
    reset = 1'b1; req = '0; req_data = '0; q_ready = 1'b0;
    model_reset();
    test_reset();
    test_round_robin();
    test_backpressure();
    test_drain();
    test_pointer_wrap();
    test_mid_reset();
    test_fairness();
    test_random(400);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
